seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Displayed value changes only at frame end, so a load never shows up half-applied.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  input  logic        lamp_test,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        load_ack,
  output logic        pending
);

  // state    | meaning
  // ST_BLANK | start of a digit slot, all anodes off to stop ghosting
  // ST_DRIVE | current digit driven (unless dark or lamp test)
  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;

  localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam state_e         ST_RESET = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  function automatic state_e slot_state(input logic [CW-1:0] c);
    return (int'(c) < BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  state_e        state_q, state_d;
  logic [15:0]   shadow_q, shadow_d, pbuf_q, pbuf_d;
  logic [3:0]    dp_shadow_q, dp_shadow_d, pdp_q, pdp_d;
  logic          pending_q, pending_d, load_ack_q, load_ack_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          wrap, commit, lz, dark;
  logic [3:0]    nib;
  logic [15:0]   upper;

  always_comb begin
    wrap        = (cnt_q >= CNT_LAST);
    cnt_d       = wrap ? '0 : cnt_q + CW'(1);
    idx_d       = wrap ? idx_q + 2'd1 : idx_q;
    // state_q always describes the slot phase of cnt_q
    state_d     = slot_state(cnt_d);

    commit      = wrap && (idx_q == 2'd3) && (pending_q || load);
    pbuf_d      = load ? data_in : pbuf_q;
    pdp_d       = load ? dp_in : pdp_q;
    shadow_d    = shadow_q;
    dp_shadow_d = dp_shadow_q;
    pending_d   = load ? 1'b1 : pending_q;
    if (commit) begin
      shadow_d    = load ? data_in : pbuf_q;
      dp_shadow_d = load ? dp_in : pdp_q;
      pending_d   = 1'b0;
    end
    load_ack_d  = commit;

    nib   = shadow_q[{idx_q, 2'b00} +: 4];
    upper = shadow_q >> {idx_q, 2'b00};
    lz    = blank_lz && (idx_q != 2'd0) && (upper == 16'h0000);
    dark  = ~digit_en[idx_q] | lz;

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (lamp_test) begin
      an_d  = 4'b0000;
      seg_d = 7'b0000000;
      dp_d  = 1'b0;
    end else if (state_q == ST_DRIVE && !dark) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(nib);
      dp_d  = ~dp_shadow_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      state_q     <= ST_RESET;
      shadow_q    <= 16'h0000;
      dp_shadow_q <= 4'h0;
      pbuf_q      <= 16'h0000;
      pdp_q       <= 4'h0;
      pending_q   <= 1'b0;
      load_ack_q  <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      pbuf_q      <= pbuf_d;
      pdp_q       <= pdp_d;
      pending_q   <= pending_d;
      load_ack_q  <= load_ack_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;
  assign load_ack = load_ack_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: time-based display model checked every cycle on two
// instances (BLANK_CYCLES=2 and 0) plus hand-computed literal expectations.
module tb_seg_scan_ctrl;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, load, blank_lz, lamp_test;
  logic [15:0] data_in;
  logic [3:0]  dp_in, digit_en;
  logic [6:0]  seg, seg0;
  logic        dp, dp0, load_ack, load_ack0, pending, pending0;
  logic [3:0]  an, an0;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .lamp_test(lamp_test),
    .seg(seg), .dp(dp), .an(an), .load_ack(load_ack), .pending(pending));

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .lamp_test(lamp_test),
    .seg(seg0), .dp(dp0), .an(an0), .load_ack(load_ack0), .pending(pending0));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model: position in the scan comes from cycles elapsed since reset release.
  int          t;
  logic [15:0] m_sh, m_pbuf;
  logic [3:0]  m_dps, m_pdp;
  logic        m_pend;
  logic [3:0]  e_an, e_an0, lit_an;
  logic [6:0]  e_seg, e_seg0, lit_seg;
  logic        e_dp, e_dp0, lit_dp, e_ack;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    int cnt, idx;
    bit dark, frame_end;
    if (!rst_n) begin
      t = 0; m_sh = 16'h0; m_pbuf = 16'h0; m_dps = 4'h0; m_pdp = 4'h0; m_pend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      e_an0 = 4'hF; e_seg0 = 7'h7F; e_dp0 = 1'b1; e_ack = 1'b0;
    end else begin
      cnt  = t % RD;
      idx  = (t / RD) % 4;
      dark = !digit_en[idx] || (blank_lz && idx != 0 && (m_sh >> (4 * idx)) == 16'h0);
      lit_an = 4'hF; lit_an[idx] = 1'b0;
      lit_seg = hex_tab[(m_sh >> (4 * idx)) & 16'hF];
      lit_dp  = !m_dps[idx];
      if (lamp_test) begin
        e_an = 4'h0; e_seg = 7'h00; e_dp = 1'b0;
        e_an0 = 4'h0; e_seg0 = 7'h00; e_dp0 = 1'b0;
      end else begin
        if (dark) begin
          e_an0 = 4'hF; e_seg0 = 7'h7F; e_dp0 = 1'b1;
        end else begin
          e_an0 = lit_an; e_seg0 = lit_seg; e_dp0 = lit_dp;
        end
        if (dark || cnt < BC) begin
          e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          e_an = lit_an; e_seg = lit_seg; e_dp = lit_dp;
        end
      end
      frame_end = (cnt == RD - 1) && (idx == 3);
      e_ack = frame_end && (m_pend || load);
      if (e_ack) begin
        m_sh   = load ? data_in : m_pbuf;
        m_dps  = load ? dp_in : m_pdp;
        m_pend = 1'b0;
      end else if (load) begin
        m_pbuf = data_in; m_pdp = dp_in; m_pend = 1'b1;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("an",        16'(an),        16'(e_an));
      chk("seg",       16'(seg),       16'(e_seg));
      chk("dp",        16'(dp),        16'(e_dp));
      chk("an_nb",     16'(an0),       16'(e_an0));
      chk("seg_nb",    16'(seg0),      16'(e_seg0));
      chk("dp_nb",     16'(dp0),       16'(e_dp0));
      chk("load_ack",  16'(load_ack),  16'(e_ack));
      chk("pending",   16'(pending),   16'(m_pend));
      chk("ack_nb",    16'(load_ack0), 16'(e_ack));
    end
  end

  task automatic wait_phase(input int ph);
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (t % FRAME == ph) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("wait_phase", 16'(ok), 16'd1);
  endtask

  task automatic wait_an(input logic [3:0] target);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an === target) begin ok = 1'b1; break; end
    end
    chk("wait_an", 16'(ok), 16'd1);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; data_in = d; dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (load_ack === 1'b1) acks++;
    end
  endtask

  initial begin
    int acks, c_a, c_b, c_c;
    bit found;
    rst_n = 1'b0; load = 1'b0; data_in = 16'h0; dp_in = 4'h0;
    digit_en = 4'hF; blank_lz = 1'b0; lamp_test = 1'b0;

    // 1: reset values and the raw anode sequence of the first two slots
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_an",  16'(an),       16'h000F);
    chk("rst_seg", 16'(seg),      16'h007F);
    chk("rst_dp",  16'(dp),       16'd1);
    chk("rst_pend",16'(pending),  16'd0);
    chk("rst_ack", 16'(load_ack), 16'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("scan_an", 16'(an), (k % 8 < 2) ? 16'h000F : (k < 8 ? 16'h000E : 16'h000D));
    end

    // 2: mid-frame load, commit at frame end, next frame shows 12AF
    wait_phase(5);
    pulse_load(16'h12AF, 4'b0100);
    chk("pend_after_load", 16'(pending), 16'd1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ack === 1'b1) begin found = 1'b1; break; end
    end
    chk("ack_seen", 16'(found), 16'd1);
    @(negedge clk);
    chk("ack_one_cycle", 16'(load_ack), 16'd0);
    wait_an(4'b1110); chk("d0_F", 16'(seg), 16'b0111000); chk("d0_dp", 16'(dp), 16'd1);
    wait_an(4'b1101); chk("d1_A", 16'(seg), 16'b0001000);
    wait_an(4'b1011); chk("d2_2", 16'(seg), 16'b0010010); chk("d2_dp", 16'(dp), 16'd0);
    wait_an(4'b0111); chk("d3_1", 16'(seg), 16'b1001111);

    // 3: overwrite before commit gives one ack; load on the commit cycle itself
    wait_phase(3);  pulse_load(16'h1111, 4'h0);
    wait_phase(10); pulse_load(16'h2222, 4'h0);
    count_acks(40, acks);
    chk("single_ack", 16'(acks), 16'd1);
    wait_an(4'b1110); chk("d0_2", 16'(seg), 16'b0010010);
    wait_phase(FRAME - 1);
    pulse_load(16'h3333, 4'h0);
    chk("coinc_pend", 16'(pending),  16'd0);
    chk("coinc_ack",  16'(load_ack), 16'd1);

    // 4: leading-zero blanking and per-digit enable
    wait_phase(FRAME - 1);
    blank_lz = 1'b1;
    pulse_load(16'h0070, 4'h0);
    @(negedge clk);
    c_a = 0; c_b = 0; c_c = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an === 4'b0111 || an === 4'b1011) c_a++;
      if (an === 4'b1101 && seg === 7'b0001111) c_b++;
      if (an === 4'b1110 && seg === 7'b0000001) c_c++;
    end
    chk("lz_hi_dark", 16'(c_a), 16'd0);
    chk("lz_d1_7",    16'(c_b), 16'd6);
    chk("lz_d0_0",    16'(c_c), 16'd6);
    wait_phase(FRAME - 1);
    pulse_load(16'h0000, 4'h0);
    @(negedge clk);
    c_a = 0; c_c = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an !== 4'b1111 && an !== 4'b1110) c_a++;
      if (an === 4'b1110 && seg === 7'b0000001) c_c++;
    end
    chk("zero_others", 16'(c_a), 16'd0);
    chk("zero_d0",     16'(c_c), 16'd6);
    blank_lz = 1'b0; digit_en = 4'b1010;
    @(negedge clk);
    c_a = 0; c_b = 0; c_c = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an === 4'b1110 || an === 4'b1011) c_a++;
      if (an === 4'b1101) c_b++;
      if (an === 4'b0111) c_c++;
    end
    chk("en_dark",  16'(c_a), 16'd0);
    chk("en_d1",    16'(c_b), 16'd6);
    chk("en_d3",    16'(c_c), 16'd6);
    digit_en = 4'hF;

    // 5: lamp test mid-slot, then continuity; no dark gaps without blank cycles
    for (int i = 0; i < 16 && (t % RD) != 4; i++) @(negedge clk);
    lamp_test = 1'b1;
    @(negedge clk);
    chk("lamp_an",  16'(an),  16'h0);
    chk("lamp_seg", 16'(seg), 16'h0);
    chk("lamp_dp",  16'(dp),  16'h0);
    chk("lamp_an_nb", 16'(an0), 16'h0);
    @(negedge clk); @(negedge clk);
    lamp_test = 1'b0;
    @(negedge clk);
    c_a = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an0 === 4'b1111) c_a++;
    end
    chk("nb_no_dark", 16'(c_a), 16'd0);

    // 6: reset with a pending load drops it
    wait_phase(FRAME - 1);
    pulse_load(16'h1234, 4'hF);
    wait_phase(5);
    pulse_load(16'h5678, 4'h0);
    wait_phase(10);
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst2_pend", 16'(pending), 16'd0);
    chk("rst2_ack",  16'(load_ack), 16'd0);
    chk("rst2_an",   16'(an), 16'h000F);
    rst_n = 1'b1;
    count_acks(40, acks);
    chk("rst2_no_ack", 16'(acks), 16'd0);
    wait_an(4'b1110);
    chk("rst2_d0_0", 16'(seg), 16'b0000001);
    chk("rst2_dp",   16'(dp),  16'd1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
